// File: rtl/regfile_pc_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : regfile_pc_core                                               |
// | Purpose  : register file (2R/1W, optional zero reg and write bypass)     |
// |            plus program counter with load/branch/step and wrap flag.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module regfile_pc_core #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_REGS = 2**ADDR_W,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1,
   parameter int PC_W     = 32,
   parameter int PC_STEP  = 4,
   parameter int PC_RESET = 0
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              write,
   input  logic [ADDR_W-1:0] read_reg_1,
   input  logic [ADDR_W-1:0] read_reg_2,
   input  logic [ADDR_W-1:0] write_reg,
   input  logic [DATA_W-1:0] write_data,
   output logic [DATA_W-1:0] read_data_1,
   output logic [DATA_W-1:0] read_data_2,
   input  logic              stall,
   input  logic              ld,
   input  logic              br,
   input  logic              inc,
   input  logic [PC_W-1:0]   pc_data_in,
   input  logic [PC_W-1:0]   br_offset,
   output logic [PC_W-1:0]   pc_data_out,
   output logic              pc_wrap
);

   localparam logic [ADDR_W:0] c_NUM_REGS = (ADDR_W+1)'(NUM_REGS);
   localparam logic [PC_W:0]   c_PC_STEP  = (PC_W+1)'(PC_STEP);
   localparam logic [PC_W-1:0] c_PC_RESET = PC_W'(PC_RESET);

   logic [DATA_W-1:0] r_regs [NUM_REGS];
   logic [PC_W-1:0]   r_pc;
   logic              r_pc_wrap;

   logic              w_wr_en;
   logic [DATA_W-1:0] w_rd1;
   logic [DATA_W-1:0] w_rd2;
   logic [PC_W:0]     w_br_sum;
   logic [PC_W:0]     w_inc_sum;
   logic [PC_W-1:0]   w_pc_nxt;
   logic              w_wrap_nxt;

   // An address is live when it maps to storage and is not the hardwired zero.
   function automatic logic f_live(input logic [ADDR_W-1:0] a);
      return ({1'b0, a} < c_NUM_REGS) && !((ZERO_REG != 0) && (a == '0));
   endfunction

   assign w_wr_en = write && f_live(write_reg);

   always_comb begin
      w_rd1 = '0;
      w_rd2 = '0;
      if (f_live(read_reg_1)) w_rd1 = r_regs[read_reg_1];
      if (f_live(read_reg_2)) w_rd2 = r_regs[read_reg_2];
      if ((BYPASS != 0) && w_wr_en && (write_reg == read_reg_1)) w_rd1 = write_data;
      if ((BYPASS != 0) && w_wr_en && (write_reg == read_reg_2)) w_rd2 = write_data;
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      end else if (w_wr_en) begin
         r_regs[write_reg] <= write_data;
      end
   end

   assign w_br_sum  = {1'b0, r_pc} + {1'b0, br_offset};
   assign w_inc_sum = {1'b0, r_pc} + c_PC_STEP;

   always_comb begin
      w_pc_nxt   = r_pc;
      w_wrap_nxt = 1'b0;
      if (stall) begin
         w_pc_nxt = r_pc;
      end else if (ld) begin
         w_pc_nxt = pc_data_in;
      end else if (br) begin
         // Negative offsets must carry out; a missing carry means underflow.
         w_pc_nxt   = w_br_sum[PC_W-1:0];
         w_wrap_nxt = br_offset[PC_W-1] ? ~w_br_sum[PC_W] : w_br_sum[PC_W];
      end else if (inc) begin
         w_pc_nxt   = w_inc_sum[PC_W-1:0];
         w_wrap_nxt = w_inc_sum[PC_W];
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_pc      <= c_PC_RESET;
         r_pc_wrap <= 1'b0;
      end else begin
         r_pc      <= w_pc_nxt;
         r_pc_wrap <= w_wrap_nxt;
      end
   end

   assign read_data_1 = w_rd1;
   assign read_data_2 = w_rd2;
   assign pc_data_out = r_pc;
   assign pc_wrap     = r_pc_wrap;

endmodule
`default_nettype wire

// File: tb/tb_regfile_pc_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_regfile_pc_core                                            |
// | Purpose  : randomized self-checking bench, two DUT configurations.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_regfile_pc_core;

   localparam longint c_MOD = 64'h1_0000_0000;

   logic        clk = 1'b0;
   logic        clr;
   logic        write;
   logic [4:0]  rr1, rr2, wr;
   logic [31:0] wd;
   logic        stall, ld, br, inc;
   logic [31:0] pcin, off;
   logic [31:0] rd1_a, rd2_a, pc_a, rd1_b, rd2_b, pc_b;
   logic        wrap_a, wrap_b;

   always #5 clk = ~clk;

   regfile_pc_core u_dut_a (
      .clk(clk), .clr(clr), .write(write),
      .read_reg_1(rr1), .read_reg_2(rr2), .write_reg(wr), .write_data(wd),
      .read_data_1(rd1_a), .read_data_2(rd2_a),
      .stall(stall), .ld(ld), .br(br), .inc(inc),
      .pc_data_in(pcin), .br_offset(off),
      .pc_data_out(pc_a), .pc_wrap(wrap_a)
   );

   regfile_pc_core #(.NUM_REGS(20), .BYPASS(0)) u_dut_b (
      .clk(clk), .clr(clr), .write(write),
      .read_reg_1(rr1), .read_reg_2(rr2), .write_reg(wr), .write_data(wd),
      .read_data_1(rd1_b), .read_data_2(rd2_b),
      .stall(stall), .ld(ld), .br(br), .inc(inc),
      .pc_data_in(pcin), .br_offset(off),
      .pc_data_out(pc_b), .pc_wrap(wrap_b)
   );

   int          checks = 0;
   int          errors = 0;
   logic [31:0] m_a [32];
   logic [31:0] m_b [32];
   longint      m_pc;
   bit          m_wrap;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         m_a[i] = '0;
         m_b[i] = '0;
      end
      m_pc   = 0;
      m_wrap = 1'b0;
   endtask

   // Config A: 32 regs with bypass; config B: 20 regs, no bypass. Both zero reg 0.
   function automatic logic [31:0] exp_rd(input bit cfg_b, input logic [4:0] a);
      int n;
      n = cfg_b ? 20 : 32;
      if (int'(a) >= n || a == 0) return '0;
      if (!cfg_b && write && wr == a) return wd;
      return cfg_b ? m_b[a] : m_a[a];
   endfunction

   task automatic model_edge();
      longint t;
      if (write && wr != 0) begin
         m_a[wr] = wd;
         if (wr < 20) m_b[wr] = wd;
      end
      if (stall) begin
         m_wrap = 1'b0;
      end else if (ld) begin
         m_pc   = longint'(pcin);
         m_wrap = 1'b0;
      end else if (br) begin
         t      = m_pc + longint'($signed(off));
         m_wrap = (t < 0) || (t >= c_MOD);
         m_pc   = t & (c_MOD - 1);
      end else if (inc) begin
         t      = m_pc + 4;
         m_wrap = (t >= c_MOD);
         m_pc   = t & (c_MOD - 1);
      end else begin
         m_wrap = 1'b0;
      end
   endtask

   task automatic check_pc(input string tag);
      check({tag, "_pc_a"},   64'(pc_a),   64'(m_pc));
      check({tag, "_wrap_a"}, 64'(wrap_a), 64'(m_wrap));
      check({tag, "_pc_b"},   64'(pc_b),   64'(m_pc));
      check({tag, "_wrap_b"}, 64'(wrap_b), 64'(m_wrap));
   endtask

   // Inputs are set just after a falling edge; reads checked before the rising edge.
   task automatic cycle(input string tag);
      #1;
      check({tag, "_rd1_a"}, 64'(rd1_a), 64'(exp_rd(1'b0, rr1)));
      check({tag, "_rd2_a"}, 64'(rd2_a), 64'(exp_rd(1'b0, rr2)));
      check({tag, "_rd1_b"}, 64'(rd1_b), 64'(exp_rd(1'b1, rr1)));
      check({tag, "_rd2_b"}, 64'(rd2_b), 64'(exp_rd(1'b1, rr2)));
      @(posedge clk);
      model_edge();
      #1;
      check_pc(tag);
      @(negedge clk);
   endtask

   task automatic idle();
      write = 0; stall = 0; ld = 0; br = 0; inc = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      clr = 0; idle(); rr1 = 0; rr2 = 0; wr = 0; wd = 0; pcin = 0; off = 0;
      model_reset();
      @(negedge clk); @(negedge clk);
      #1;
      check_pc("reset");
      check("reset_rd1_a", 64'(rd1_a), 64'(0));
      clr = 1;
      @(negedge clk);

      // Bypass on A, old value on B until the edge
      write = 1; wr = 3; wd = 32'h1234; rr1 = 3; rr2 = 4;
      cycle("byp");
      idle();
      cycle("byp_after");

      // Zero register and out-of-range read on B
      write = 1; wr = 0; wd = 32'hFFFF_FFFF; rr1 = 0; rr2 = 25;
      cycle("zero");
      write = 1; wr = 25; wd = 32'hCAFE_0025; rr1 = 25; rr2 = 0;
      cycle("oor_wr");
      idle(); rr1 = 25; rr2 = 19;
      cycle("oor_rd");

      idle(); ld = 1; pcin = 32'hFFFF_FFFC;
      cycle("ld_top");
      idle(); inc = 1;
      cycle("inc_wrap");
      idle();
      cycle("hold");
      ld = 1; pcin = 32'h100;
      cycle("ld_100");
      idle(); br = 1; off = -32'sd8;
      cycle("br_neg");
      idle(); ld = 1; pcin = 32'h4;
      cycle("ld_4");
      idle(); br = 1; off = -32'sd8;
      cycle("br_under");
      idle(); ld = 1; pcin = 32'hFFFF_FFF0;
      cycle("ld_fff0");
      idle(); br = 1; off = 32'h20;
      cycle("br_over");

      idle(); stall = 1; ld = 1; inc = 1; pcin = 32'h55;
      cycle("stall_pri");
      idle(); ld = 1; br = 1; inc = 1; pcin = 32'h200; off = 32'h10;
      cycle("ld_pri");
      idle(); ld = 1; pcin = 32'h100;
      cycle("ld_100b");
      idle(); br = 1; inc = 1; off = 32'h10;
      cycle("br_pri");

      // Asynchronous reset mid-run
      idle(); ld = 1; pcin = 32'h40; write = 1; wr = 5; wd = 32'hDEAD;
      cycle("pre_clr");
      idle(); rr1 = 5; rr2 = 3;
      #2;
      clr = 0;
      #1;
      model_reset();
      check_pc("clr_async");
      check("clr_rd1_a", 64'(rd1_a), 64'(0));
      check("clr_rd2_b", 64'(rd2_b), 64'(0));
      ld = 1; pcin = 32'h77; write = 1; wr = 6; wd = 32'h66;
      @(posedge clk); #1;
      check_pc("clr_hold");
      @(negedge clk);
      idle(); clr = 1; rr1 = 6;
      cycle("post_clr");

      for (int i = 0; i < 400; i++) begin
         write = $urandom_range(1, 0);
         wr    = 5'($urandom);
         wd    = $urandom;
         rr1   = ($urandom_range(3, 0) == 0) ? wr : 5'($urandom);
         rr2   = ($urandom_range(3, 0) == 0) ? wr : 5'($urandom);
         stall = ($urandom_range(7, 0) == 0);
         ld    = ($urandom_range(4, 0) == 0);
         br    = ($urandom_range(2, 0) == 0);
         inc   = $urandom_range(1, 0);
         pcin  = $urandom_range(1, 0) ? (32'hFFFF_FF00 | 32'($urandom_range(255, 0))) : $urandom;
         off   = $urandom_range(1, 0) ? 32'($signed($urandom_range(512, 0)) - 256) : $urandom;
         cycle("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
